shift_unit: RTL
===============

Name: shift_unit

Overview:
- Multi-cycle shifter directly downstream of the ALU control decoder.
- Consumes its 3-bit shifter command and its load-then-shift sequence.
- Captures an operand and shift amount, then shifts one bit per cycle (iterative) until complete.
- Result feeds the ALUOut source mux (shifter leg). `busy` and `done` let the main control FSM wait for completion.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- shift_ctrl  input  3  command: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROR, 110/111 reserved (treated as NOP).
- data_in  input  WIDTH  operand captured on LOAD (upstream mux already selects register/immediate).
- shamt_in  input  SHAMT_W  shift amount captured on LOAD.
- data_out  output  WIDTH  shift register contents.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when a shift completes.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, data_out=0, shamt register=0, counter=0, busy=0, done=0. Reset overrides any command and aborts an in-flight shift.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, LOAD: data_out<=data_in, shamt_reg<=shamt_in, stay IDLE. done stays 0.
- IDLE, shift cmd (SLL/SRL/SRA/ROR):
  - Latch the op.
  - If shamt_reg==0: go to DONE; data unchanged.
  - Otherwise: counter<=shamt_reg, go to SHIFT.
- SHIFT: each edge applies a 1-bit shift of the latched op and decrements counter. When counter==1, go to DONE.
  - SLL: zero fill at LSB.
  - SRL: zero fill at MSB.
  - SRA: MSB replicated.
  - ROR: old LSB moves to MSB.
- DONE: done=1 for exactly one cycle, then IDLE. Commands in DONE are handled exactly as in IDLE, so back-to-back ops lose no cycle.
- Latency: a shift command sampled at edge E0 with amount n gives the final data_out after edge E(max(n,1)-1)+1. done is high in the cycle after the last shift edge. For n=0, done is high in the cycle after E0.
- busy: 1 exactly when state==SHIFT; combinational from state.
- Commands in SHIFT:
  - LOAD aborts the shift: data_out<=data_in, shamt_reg<=shamt_in, go to IDLE, no done pulse.
  - NOP or a shift command is ignored.
- Reserved codes behave as NOP in every state.
- shamt_reg persists across shifts, so repeated shift commands without a new LOAD reuse it.
- data_out changes only on LOAD or shift edges; it is stable in IDLE and DONE.

Optional Feature:
- Macro: SHIFT_UNIT_BARREL_EN.
- Defined: a shift command in IDLE/DONE computes the full shift in one edge via a barrel shifter, goes straight to DONE, and SHIFT is never entered (busy stays 0). Latency is one edge for every n, including n=0.
- Undefined: iterative behaviour as above.
- Port list is identical in both builds.

Decomposition:
- Package shift_pkg holds:
  - command code constants (SH_NOP, SH_LOAD, SH_SLL, SH_SRL, SH_SRA, SH_ROR);
  - FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - WIDTH/SHAMT_W defaults.
- One sub-module, shift_step: combinational 1-bit shift by op. In the barrel build it is replaced by an n-bit variant selected under the macro.

Test Plan:
- Reset: hold reset=0 for 2 edges mid-SLL by 20 -> data_out=0, busy=0, done=0, state IDLE; after release, NOP keeps data_out=0.
- SLL: LOAD 0x0000_0001 with shamt 4, then SLL -> busy high 4 cycles, data_out=0x0000_0010, done pulses once, then IDLE.
- SRA: LOAD 0x8000_0000 with shamt 31, then SRA -> data_out=0xFFFF_FFFF after 31 shift edges. Repeat with SRL -> 0x0000_0001.
- LUI-style SLL and ROR: LOAD 0x0000_1234 with shamt 16, then SLL -> 0x1234_0000. LOAD 0x0000_00F1 with shamt 4, then ROR -> 0x1000_000F.
- Zero amount: LOAD 0xDEAD_BEEF with shamt 0, then SRL -> busy never high, done in the next cycle, data_out=0xDEAD_BEEF.
- Abort and ignore: during SLL by 8, issue SRL (ignored, shift continues). Then LOAD 0xA5A5_A5A5 -> immediate IDLE, data_out=0xA5A5_A5A5, no done pulse. Reserved code 111 in IDLE -> no change.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared command codes, FSM encoding and default sizes for the shift unit.
// Used by both the iterative build and the SHIFT_UNIT_BARREL_EN build.
package shift_pkg;

    localparam int SHIFT_WIDTH   = 32;
    localparam int SHIFT_SHAMT_W = 5;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic logic is_shift_cmd(input logic [2:0] cmd);
        return (cmd == SH_SLL) || (cmd == SH_SRL) || (cmd == SH_SRA) || (cmd == SH_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift datapath: one bit per call by default, or a full
// n-bit barrel shift when SHIFT_UNIT_BARREL_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH   = SHIFT_WIDTH,
    parameter int SHAMT_W = SHIFT_SHAMT_W
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [2:0]         op_i,
`ifdef SHIFT_UNIT_BARREL_EN
    input  logic [SHAMT_W-1:0] amt_i,
`endif
    output logic [WIDTH-1:0]   data_o
);

`ifdef SHIFT_UNIT_BARREL_EN
    logic [2*WIDTH-1:0] rot_dbl;

    always_comb begin
        // Rotating the doubled word right leaves the rotation in the low half.
        rot_dbl = {data_i, data_i} >> amt_i;
        case (op_i)
            SH_SLL:  data_o = data_i << amt_i;
            SH_SRL:  data_o = data_i >> amt_i;
            SH_SRA:  data_o = WIDTH'($signed(data_i) >>> amt_i);
            SH_ROR:  data_o = rot_dbl[WIDTH-1:0];
            default: data_o = data_i;
        endcase
    end
`else
    always_comb begin
        case (op_i)
            SH_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
            SH_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
            SH_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            SH_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            default: data_o = data_i;
        endcase
    end
`endif

endmodule

// File: rtl/shift_unit.sv
// Load-then-shift unit feeding the ALUOut shifter leg. Iterative (1 bit/cycle)
// by default; SHIFT_UNIT_BARREL_EN makes every shift complete in one edge.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = SHIFT_WIDTH,
    parameter int SHAMT_W = SHIFT_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         shift_ctrl,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [WIDTH-1:0]   step_out;

`ifdef SHIFT_UNIT_BARREL_EN
    shift_step #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_step (
        .data_i (data_q),
        .op_i   (shift_ctrl),
        .amt_i  (shamt_q),
        .data_o (step_out)
    );
`else
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;

    shift_step #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .data_o (step_out)
    );
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
`ifndef SHIFT_UNIT_BARREL_EN
        cnt_d   = cnt_q;
        op_d    = op_q;
`endif
        case (state_q)
            // DONE accepts commands exactly like IDLE so back-to-back ops lose no cycle.
            IDLE, DONE: begin
                state_d = IDLE;
                if (shift_ctrl == SH_LOAD) begin
                    data_d  = data_in;
                    shamt_d = shamt_in;
                end else if (is_shift_cmd(shift_ctrl)) begin
`ifdef SHIFT_UNIT_BARREL_EN
                    data_d  = step_out;
                    state_d = DONE;
`else
                    op_d = shift_ctrl;
                    if (shamt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = shamt_q;
                        state_d = SHIFT;
                    end
`endif
                end
            end
            SHIFT: begin
`ifdef SHIFT_UNIT_BARREL_EN
                state_d = IDLE;
`else
                if (shift_ctrl == SH_LOAD) begin
                    data_d  = data_in;
                    shamt_d = shamt_in;
                    state_d = IDLE;
                end else begin
                    data_d = step_out;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
`ifndef SHIFT_UNIT_BARREL_EN
            cnt_q   <= '0;
            op_q    <= SH_NOP;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
`ifndef SHIFT_UNIT_BARREL_EN
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`endif
        end
    end

    assign data_out = data_q;
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

endmodule
